// File: rtl/reg_wb_ctrl_if.sv
// Bundle of the write-request handshake, register-file write port, hazard
// check lookups and occupancy between the datapath and reg_wb_ctrl.
interface reg_wb_ctrl_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              reg_write_ctrl;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
  logic [CW-1:0]     pending_cnt;

  modport master (
    output req_valid, req_addr, req_data, chk_addr1, chk_addr2,
    input  req_ready, w_addr, w_data, reg_write_ctrl,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, pending_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data, chk_addr1, chk_addr2,
    output req_ready, w_addr, w_data, reg_write_ctrl,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, pending_cnt
  );
endinterface

// File: rtl/reg_wb_ctrl.sv
// Write-back controller: buffers register writes in a small FIFO and drains
// them into a level-sensitive register-file port with setup/strobe/hold.
module reg_wb_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_wb_ctrl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_cnt;
  state_t            r_state;
  logic [ADDR_W-1:0] r_w_addr;
  logic [DATA_W-1:0] r_w_data;
  logic              r_wce;

  logic              w_ready, w_push, w_pop, w_more;
  logic [PW-1:0]     w_nidx;
  logic [ADDR_W-1:0] w_naddr;
  logic [DATA_W-1:0] w_ndata;
  logic [ADDR_W-1:0] w_chk [2];
  logic [1:0]        w_hit;
  logic [DATA_W-1:0] w_fwd [2];

  // Writes to R0 complete the handshake but are dropped.
  assign w_ready = (r_cnt != CW'(DEPTH));
  assign w_push  = bus.req_valid && w_ready && (bus.req_addr != '0);
  assign w_pop   = (r_state == HOLD);

  // Next head after the HOLD pop; with one entry left it is the same-edge push.
  assign w_nidx  = r_rptr + PW'(1);
  assign w_more  = (r_cnt > CW'(1)) || w_push;
  assign w_naddr = (r_cnt > CW'(1)) ? r_addr[w_nidx] : bus.req_addr;
  assign w_ndata = (r_cnt > CW'(1)) ? r_data[w_nidx] : bus.req_data;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= bus.req_addr;
      r_data[r_wptr] <= bus.req_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_state  <= IDLE;
      r_w_addr <= '0;
      r_w_data <= '0;
      r_wce    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
      case (r_state)
        IDLE: begin
          r_wce <= 1'b0;
          if (r_cnt != '0) begin
            r_w_addr <= r_addr[r_rptr];
            r_w_data <= r_data[r_rptr];
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_wce   <= 1'b1;
          r_state <= STROBE;
        end
        STROBE: begin
          r_wce   <= 1'b0;
          r_state <= HOLD;
        end
        default: begin
          r_wce <= 1'b0;
          if (w_more) begin
            r_w_addr <= w_naddr;
            r_w_data <= w_ndata;
            r_state  <= SETUP;
          end else begin
            r_state  <= IDLE;
          end
        end
      endcase
    end
  end

  assign w_chk[0] = bus.chk_addr1;
  assign w_chk[1] = bus.chk_addr2;

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx   = '0;
    w_hit = '0;
    for (int p = 0; p < 2; p++) begin
      w_fwd[p] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = r_rptr + PW'(k);
        if ((CW'(k) < r_cnt) && (w_chk[p] != '0) && (r_addr[idx] == w_chk[p])) begin
          w_hit[p] = 1'b1;
          w_fwd[p] = r_data[idx];
        end
      end
    end
  end

  assign bus.req_ready      = w_ready;
  assign bus.w_addr         = r_w_addr;
  assign bus.w_data         = r_w_data;
  assign bus.reg_write_ctrl = r_wce;
  assign bus.fwd_hit1       = w_hit[0];
  assign bus.fwd_hit2       = w_hit[1];
  assign bus.fwd_data1      = w_fwd[0];
  assign bus.fwd_data2      = w_fwd[1];
  assign bus.pending_cnt    = r_cnt;
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Bench for reg_wb_ctrl: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of buffered writes and drain phases.
module tb_reg_wb_ctrl;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_wb_ctrl_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_wb_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  // Model: queue of buffered writes; when busy, ph 0/1/2 = setup/strobe/hold.
  ent_t              q[$];
  bit                busy;
  int                ph;
  logic [ADDR_W-1:0] m_wa;
  logic [DATA_W-1:0] m_wd;
  int                ncmp = 0;
  int                nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    busy = 0;
    ph   = 0;
    m_wa = '0;
    m_wd = '0;
  endtask

  task automatic check();
    bit                h1, h2;
    logic [DATA_W-1:0] d1, d2;
    h1 = 0; h2 = 0; d1 = '0; d2 = '0;
    foreach (q[i]) begin
      if (bus.chk_addr1 != 0 && q[i].a == bus.chk_addr1) begin h1 = 1; d1 = q[i].d; end
      if (bus.chk_addr2 != 0 && q[i].a == bus.chk_addr2) begin h2 = 1; d2 = q[i].d; end
    end
    chk("req_ready", bus.req_ready, q.size() != DEPTH);
    chk("pending_cnt", bus.pending_cnt, q.size());
    chk("reg_write_ctrl", bus.reg_write_ctrl, busy && ph == 1);
    chk("w_addr", bus.w_addr, m_wa);
    chk("w_data", bus.w_data, m_wd);
    chk("fwd_hit1", bus.fwd_hit1, h1);
    chk("fwd_hit2", bus.fwd_hit2, h2);
    chk("fwd_data1", bus.fwd_data1, d1);
    chk("fwd_data2", bus.fwd_data2, d2);
  endtask

  // One clock: evaluate the handshake on pre-edge inputs, advance model, check.
  task automatic cyc();
    bit   push;
    ent_t e;
    push = bus.req_valid && (q.size() != DEPTH) && (bus.req_addr != 0);
    e.a  = bus.req_addr;
    e.d  = bus.req_data;
    @(posedge clk);
    if (busy) begin
      if (ph < 2) ph++;
      else begin
        void'(q.pop_front());
        if (push) q.push_back(e);
        push = 0;
        busy = q.size() > 0;
        ph   = 0;
        if (busy) begin m_wa = q[0].a; m_wd = q[0].d; end
      end
    end else if (q.size() > 0) begin
      busy = 1; ph = 0; m_wa = q[0].a; m_wd = q[0].d;
    end
    if (push) q.push_back(e);
    #1 check();
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Present one request and hold it until the model says it was accepted.
  task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit rdy;
    int n;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    n = 0;
    do begin
      rdy = (q.size() != DEPTH);
      cyc();
      n++;
    end while (!rdy && n < 20);
    if (!rdy) begin
      ncmp++; nfail++;
      $display("FAIL send_accept: request addr %0d not accepted within 20 cycles", a);
    end
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.chk_addr1 = '0;
    bus.chk_addr2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check();
    rst_n = 1'b1;

    // Single write, then drain.
    send(5'd5, 32'hDEADBEEF);
    idle(6);

    // Burst of six with valid held; FIFO fills and backpressures.
    for (int k = 1; k <= 6; k++) send(ADDR_W'(k), 32'hA000_0000 + 32'(k));
    idle(25);

    // Two writes to the same register; forwarding must return the younger one.
    bus.chk_addr1 = 5'd7;
    bus.chk_addr2 = 5'd7;
    send(5'd7, 32'h11);
    send(5'd7, 32'h22);
    idle(12);

    // R0 write is swallowed; R0 lookup never hits.
    bus.chk_addr1 = 5'd0;
    send(5'd0, 32'hFFFFFFFF);
    idle(6);

    // Random traffic over a small address range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = ($urandom_range(0, 9) < 6);
      bus.req_addr  = ADDR_W'($urandom_range(0, 7));
      bus.req_data  = $urandom;
      bus.chk_addr1 = ADDR_W'($urandom_range(0, 7));
      bus.chk_addr2 = ADDR_W'($urandom_range(0, 7));
      cyc();
    end
    idle(20);

    // Reset pulse during the strobe of the first of three pending writes.
    bus.chk_addr1 = 5'd2;
    bus.chk_addr2 = 5'd3;
    send(5'd1, 32'h101);
    send(5'd2, 32'h202);
    send(5'd3, 32'h303);
    bus.req_valid = 1'b0;
    n = 0;
    while (!(busy && ph == 1) && n < 20) begin cyc(); n++; end
    if (!(busy && ph == 1)) begin
      ncmp++; nfail++;
      $display("FAIL strobe_wait: strobe phase not reached within 20 cycles");
    end
    chk("pending_before_reset", bus.pending_cnt, 3);
    rst_n = 1'b0;
    #2;
    model_reset();
    check();
    #2 rst_n = 1'b1;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
